// File: rtl/arfs_pkg.sv
// Shared types for the flow-steering table: command/response encodings and the CAM entry layout.
// Entry fields are sized to the widest supported key/qid; instances zero-extend narrower values.
package arfs_pkg;

  localparam int MAX_KEY_W = 32;
  localparam int MAX_QID_W = 16;

  typedef enum logic [1:0] {
    OP_INSERT = 2'b00,
    OP_UPDATE = 2'b01,
    OP_DELETE = 2'b10,
    OP_FLUSH  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DUP      = 2'b01,
    ST_NOTFOUND = 2'b10,
    ST_FULL     = 2'b11
  } rsp_status_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_KEY_W-1:0] key;
    logic [MAX_QID_W-1:0] qid;
  } entry_t;

endpackage

// File: rtl/arfs_cam.sv
// Flow table storage with two parallel match ports (packet lookup, command search),
// a lowest-index free-slot encoder and single-entry write/clear plus flush-all.
module arfs_cam #(
  parameter int KEY_W   = 12,
  parameter int QID_W   = 11,
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [KEY_W-1:0] lk_key,
  output logic             lk_hit,
  output logic [QID_W-1:0] lk_qid,
  input  logic [KEY_W-1:0] cm_key,
  output logic             cm_hit,
  output logic [IDX_W-1:0] cm_hit_idx,
  output logic             free,
  output logic [IDX_W-1:0] free_idx,
  input  logic             wr_en,
  input  logic             clr_en,
  input  logic             flush,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [QID_W-1:0] wr_qid
);
  import arfs_pkg::*;

  entry_t ent [ENTRIES];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush) begin
          ent[i].valid <= 1'b0;
        end else if (wr_en && wr_idx == IDX_W'(i)) begin
          ent[i].valid <= 1'b1;
          ent[i].key   <= MAX_KEY_W'(wr_key);
          ent[i].qid   <= MAX_QID_W'(wr_qid);
        end else if (clr_en && wr_idx == IDX_W'(i)) begin
          ent[i].valid <= 1'b0;
        end
      end
    end
  end

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    lk_hit     = 1'b0;
    lk_qid     = '0;
    cm_hit     = 1'b0;
    cm_hit_idx = '0;
    free       = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].key == MAX_KEY_W'(lk_key)) begin
        lk_hit = 1'b1;
        lk_qid = ent[i].qid[QID_W-1:0];
      end
      if (ent[i].valid && ent[i].key == MAX_KEY_W'(cm_key)) begin
        cm_hit     = 1'b1;
        cm_hit_idx = IDX_W'(i);
      end
      if (!ent[i].valid) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/arfs_steer_table.sv
// Receive-flow steering stage: tags every beat with the qid looked up from the first beat's key.
// Optional hit/miss statistics are enabled with ARFS_STEER_STATS_EN.
module arfs_steer_table #(
  parameter int DATA_W      = 512,
  parameter int KEY_W       = 12,
  parameter int KEY_LSB     = 112,
  parameter int QID_W       = 11,
  parameter int ENTRIES     = 16,
  parameter int DEFAULT_QID = 0
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic [15:0]         s_axis_tuser_size,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic [15:0]         m_axis_tuser_size,
  output logic [QID_W-1:0]    m_axis_tuser_qid,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [KEY_W-1:0]    cmd_key,
  input  logic [QID_W-1:0]    cmd_qid,
  output logic                rsp_valid,
  output logic [1:0]          rsp_status
`ifdef ARFS_STEER_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [31:0]         stat_hit_cnt,
  output logic [31:0]         stat_miss_cnt
`endif
);
  import arfs_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE, S_RESP} state_e;

  logic             sop;
  logic             s_fire;
  logic             lk_hit;
  logic [QID_W-1:0] lk_qid;
  logic             cm_hit, free;
  logic [IDX_W-1:0] cm_hit_idx, free_idx;
  logic             wr_en, clr_en, flush;
  logic [IDX_W-1:0] wr_idx;

  state_e           state_q, state_d;
  cmd_op_e          op_q;
  logic [KEY_W-1:0] key_q;
  logic [QID_W-1:0] qid_q;
  logic             srch_hit_q, srch_free_q;
  logic [IDX_W-1:0] srch_hit_idx_q, srch_free_idx_q;
  rsp_status_e      status_d;

  arfs_cam #(.KEY_W(KEY_W), .QID_W(QID_W), .ENTRIES(ENTRIES)) u_cam (
    .clk        (clk),
    .aresetn    (aresetn),
    .lk_key     (s_axis_tdata[KEY_LSB +: KEY_W]),
    .lk_hit     (lk_hit),
    .lk_qid     (lk_qid),
    .cm_key     (key_q),
    .cm_hit     (cm_hit),
    .cm_hit_idx (cm_hit_idx),
    .free       (free),
    .free_idx   (free_idx),
    .wr_en      (wr_en),
    .clr_en     (clr_en),
    .flush      (flush),
    .wr_idx     (wr_idx),
    .wr_key     (key_q),
    .wr_qid     (qid_q)
  );

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  // Non-first beats leave m_axis_tuser_qid untouched, so it carries the packet's latched qid.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser_size <= '0;
      m_axis_tuser_qid  <= QID_W'(DEFAULT_QID);
      sop               <= 1'b1;
    end else if (s_fire) begin
      m_axis_tvalid     <= 1'b1;
      m_axis_tdata      <= s_axis_tdata;
      m_axis_tkeep      <= s_axis_tkeep;
      m_axis_tlast      <= s_axis_tlast;
      m_axis_tuser_size <= s_axis_tuser_size;
      if (sop) m_axis_tuser_qid <= lk_hit ? lk_qid : QID_W'(DEFAULT_QID);
      sop               <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    clr_en   = 1'b0;
    flush    = 1'b0;
    wr_idx   = srch_hit_idx_q;
    status_d = ST_OK;
    case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_SEARCH;
      S_SEARCH: state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_RESP;
        case (op_q)
          OP_INSERT: begin
            if (srch_hit_q)       status_d = ST_DUP;
            else if (!srch_free_q) status_d = ST_FULL;
            else begin
              wr_en  = 1'b1;
              wr_idx = srch_free_idx_q;
            end
          end
          OP_UPDATE: if (srch_hit_q) wr_en  = 1'b1; else status_d = ST_NOTFOUND;
          OP_DELETE: if (srch_hit_q) clr_en = 1'b1; else status_d = ST_NOTFOUND;
          OP_FLUSH:  flush = 1'b1;
        endcase
      end
      S_RESP:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      op_q            <= OP_INSERT;
      key_q           <= '0;
      qid_q           <= '0;
      srch_hit_q      <= 1'b0;
      srch_free_q     <= 1'b0;
      srch_hit_idx_q  <= '0;
      srch_free_idx_q <= '0;
      rsp_status      <= 2'b00;
    end else begin
      if (state_q == S_IDLE && cmd_valid) begin
        op_q  <= cmd_op_e'(cmd_op);
        key_q <= cmd_key;
        qid_q <= cmd_qid;
      end
      if (state_q == S_SEARCH) begin
        srch_hit_q      <= cm_hit;
        srch_hit_idx_q  <= cm_hit_idx;
        srch_free_q     <= free;
        srch_free_idx_q <= free_idx;
      end
      if (state_q == S_WRITE) rsp_status <= status_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);

`ifdef ARFS_STEER_STATS_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (stat_clr) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (s_fire && sop) begin
      if (lk_hit && stat_hit_cnt != 32'hFFFF_FFFF)   stat_hit_cnt  <= stat_hit_cnt + 32'd1;
      if (!lk_hit && stat_miss_cnt != 32'hFFFF_FFFF) stat_miss_cnt <= stat_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arfs_steer_table.sv
// Bench for arfs_steer_table: directed scenarios plus randomized traffic against a key->qid map model.
// Build with ARFS_STEER_STATS_EN defined to also cover the hit/miss counters.
module tb_arfs_steer_table;
  localparam int DATA_W = 512, KEY_W = 12, KEY_LSB = 112, QID_W = 11, ENTRIES = 16, DEFAULT_QID = 0;
  localparam logic [1:0] OK = 2'd0, DUP = 2'd1, NF = 2'd2, FULL = 2'd3;
  localparam logic [1:0] INS = 2'd0, UPD = 2'd1, DEL = 2'd2, FLU = 2'd3;

  logic clk = 1'b0, aresetn = 1'b0;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic [15:0] s_axis_tuser_size = '0, m_axis_tuser_size;
  logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic [QID_W-1:0] m_axis_tuser_qid, cmd_qid = '0;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid;
  logic [1:0] cmd_op = '0, rsp_status;
  logic [KEY_W-1:0] cmd_key = '0;
`ifdef ARFS_STEER_STATS_EN
  logic stat_clr = 1'b0;
  logic [31:0] stat_hit_cnt, stat_miss_cnt;
`endif

  always #5 clk = ~clk;

  arfs_steer_table #(.DATA_W(DATA_W), .KEY_W(KEY_W), .KEY_LSB(KEY_LSB), .QID_W(QID_W),
                     .ENTRIES(ENTRIES), .DEFAULT_QID(DEFAULT_QID)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast), .s_axis_tuser_size(s_axis_tuser_size),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser_size(m_axis_tuser_size),
    .m_axis_tuser_qid(m_axis_tuser_qid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_qid(cmd_qid),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status)
`ifdef ARFS_STEER_STATS_EN
    , .stat_clr(stat_clr), .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur", nm);
  endtask

  // Reference model: key->qid map, expected output beats, command timing.
  typedef struct {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic                last;
    logic [15:0]         size;
    logic [QID_W-1:0]    qid;
  } beat_t;

  logic [QID_W-1:0] tbl [bit [KEY_W-1:0]];
  beat_t exp_q[$];
  logic [QID_W-1:0] obs_first_qid[$];
  int cyc = 0, wr_cyc = -10, rsp_cyc = -10, busy_until = -1;
  int rsp_cnt = 0, stall_seen = 0;
  int stall_from = -100, stall_len = 0;
  bit rand_bp = 0;
  logic [1:0] pend_op, pend_status, last_status;
  logic [KEY_W-1:0] pend_key;
  logic [QID_W-1:0] pend_qid, cur_qid;
  bit in_sop = 1, out_sop = 1, prev_acc = 0, prev_stall = 0;
  beat_t snap;
  int unsigned mdl_hit = 0, mdl_miss = 0;

  always @(negedge clk) begin
    beat_t e;
    bit [KEY_W-1:0] k;
    cyc = cyc + 1;
    if (!aresetn) begin
      tbl.delete();
      exp_q.delete();
      in_sop = 1; out_sop = 1; prev_acc = 0; prev_stall = 0;
      wr_cyc = -10; rsp_cyc = -10; busy_until = -1;
      mdl_hit = 0; mdl_miss = 0;
    end else begin
      if (prev_acc) chk("latency_1", m_axis_tvalid, 1);
      if (prev_stall) begin
        chk("bp_valid_held", m_axis_tvalid, 1);
        chkw("bp_data_held", m_axis_tdata, snap.data);
        chk("bp_last_held", m_axis_tlast, snap.last);
        chk("bp_qid_held", m_axis_tuser_qid, snap.qid);
      end
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) fail("unexpected_beat");
        else begin
          e = exp_q[0];
          chkw("m_tdata", m_axis_tdata, e.data);
          chk("m_tkeep", m_axis_tkeep, e.keep);
          chk("m_tlast", m_axis_tlast, e.last);
          chk("m_tuser_size", m_axis_tuser_size, e.size);
          chk("m_tuser_qid", m_axis_tuser_qid, e.qid);
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            if (out_sop) obs_first_qid.push_back(e.qid);
            out_sop = e.last;
          end
        end
      end
      chk("s_tready", s_axis_tready, (!m_axis_tvalid || m_axis_tready) ? 1 : 0);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      if (prev_stall) stall_seen++;
      snap.data = m_axis_tdata; snap.last = m_axis_tlast; snap.qid = m_axis_tuser_qid;

      prev_acc = s_axis_tvalid && s_axis_tready;
      if (prev_acc) begin
        if (in_sop) begin
          k = s_axis_tdata[KEY_LSB +: KEY_W];
          if (tbl.exists(k)) begin cur_qid = tbl[k]; mdl_hit++; end
          else begin cur_qid = QID_W'(DEFAULT_QID); mdl_miss++; end
        end
        e.data = s_axis_tdata; e.keep = s_axis_tkeep; e.last = s_axis_tlast;
        e.size = s_axis_tuser_size; e.qid = cur_qid;
        exp_q.push_back(e);
        in_sop = s_axis_tlast;
      end
`ifdef ARFS_STEER_STATS_EN
      if (stat_clr) begin mdl_hit = 0; mdl_miss = 0; end
`endif

      // Table change lands on the same edge as a lookup above, which must still see the old map.
      if (cyc == wr_cyc) begin
        k = pend_key;
        case (pend_op)
          INS: if (tbl.exists(k)) pend_status = DUP;
               else if (tbl.num() >= ENTRIES) pend_status = FULL;
               else begin tbl[k] = pend_qid; pend_status = OK; end
          UPD: if (tbl.exists(k)) begin tbl[k] = pend_qid; pend_status = OK; end else pend_status = NF;
          DEL: if (tbl.exists(k)) begin tbl.delete(k); pend_status = OK; end else pend_status = NF;
          default: begin tbl.delete(); pend_status = OK; end
        endcase
      end
      chk("rsp_valid", rsp_valid, (cyc == rsp_cyc) ? 1 : 0);
      if (cyc == rsp_cyc) begin
        chk("rsp_status", rsp_status, pend_status);
        last_status = rsp_status;
        rsp_cnt++;
      end
      chk("cmd_ready", cmd_ready, (cyc > busy_until) ? 1 : 0);
      if (cmd_valid && cmd_ready) begin
        pend_op = cmd_op; pend_key = cmd_key; pend_qid = cmd_qid;
        wr_cyc = cyc + 2; rsp_cyc = cyc + 3; busy_until = cyc + 3;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cyc >= stall_from && cyc < stall_from + stall_len) m_axis_tready = 1'b0;
    else if (rand_bp) m_axis_tready = ($urandom_range(0, 3) != 0);
    else m_axis_tready = 1'b1;
  end

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_pkt(input logic [KEY_W-1:0] key, input int nb);
    logic [DATA_W-1:0] d;
    logic [DATA_W/8-1:0] kp;
    logic [15:0] sz;
    bit acc;
    int t;
    sz = 16'(nb * 64 - int'($urandom_range(0, 63)));
    @(posedge clk); #1;
    for (int b = 0; b < nb; b++) begin
      d = rnd_data();
      if (b == 0) d[KEY_LSB +: KEY_W] = key;
      kp = '1;
      if (b == nb - 1) kp = kp >> $urandom_range(0, 63);
      s_axis_tdata = d; s_axis_tkeep = kp; s_axis_tuser_size = sz;
      s_axis_tlast = (b == nb - 1); s_axis_tvalid = 1'b1;
      t = 0;
      do begin
        @(negedge clk); acc = s_axis_tready;
        @(posedge clk); #1; t++;
      end while (!acc && t < 200);
      if (!acc) fail("s_accept_timeout");
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [KEY_W-1:0] k, input logic [QID_W-1:0] q,
                        output logic [1:0] st);
    int n0, t;
    n0 = rsp_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_key = k; cmd_qid = q;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 50);
    @(posedge clk); #1; cmd_valid = 1'b0;
    if (t >= 50) fail("cmd_accept_timeout");
    t = 0;
    while (rsp_cnt == n0 && t < 20) begin @(posedge clk); t++; end
    if (rsp_cnt == n0) fail("rsp_timeout");
    st = last_status;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 500) begin @(posedge clk); t++; end
    if (t >= 500) fail("drain_timeout");
  endtask

  task automatic expect_last_qid(input string nm, input logic [QID_W-1:0] q);
    drain();
    if (obs_first_qid.size() == 0) fail(nm);
    else chk(nm, obs_first_qid[$], q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] st;
    int s0;
    repeat (3) @(posedge clk); #1;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_qid", m_axis_tuser_qid, DEFAULT_QID);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chkw("rst_m_tdata", m_axis_tdata, '0);
    aresetn = 1'b1;

    send_pkt(12'h0F0, 1);
    expect_last_qid("t1_miss_qid", 11'h000);

    do_cmd(INS, 12'h0F0, 11'h0FA, st); chk("t2_insert_ok", st, OK);
    send_pkt(12'h0F0, 3);
    expect_last_qid("t2_hit_qid", 11'h0FA);

    do_cmd(UPD, 12'h0F0, 11'h0FB, st); chk("t3_update_ok", st, OK);
    send_pkt(12'h0F0, 2);
    expect_last_qid("t3_updated_qid", 11'h0FB);
    do_cmd(DEL, 12'h0F0, 11'h000, st); chk("t3_delete_ok", st, OK);
    send_pkt(12'h0F0, 1);
    expect_last_qid("t3_deleted_qid", 11'h000);
    do_cmd(DEL, 12'h0F0, 11'h000, st); chk("t3_delete_nf", st, NF);

    for (int i = 0; i < ENTRIES; i++) begin
      do_cmd(INS, 12'h100 + 12'(i), 11'h400 + 11'(i), st);
      chk("t4_insert_ok", st, OK);
    end
    do_cmd(INS, 12'h1FF, 11'h7FF, st); chk("t4_full", st, FULL);
    do_cmd(INS, 12'h103, 11'h001, st); chk("t4_dup", st, DUP);
    send_pkt(12'h10F, 1);
    expect_last_qid("t4_last_entry_qid", 11'h40F);
    do_cmd(FLU, 12'h000, 11'h000, st); chk("t4_flush_ok", st, OK);
    send_pkt(12'h100, 1);
    expect_last_qid("t4_flushed_first", 11'h000);
    send_pkt(12'h10F, 1);
    expect_last_qid("t4_flushed_last", 11'h000);

    s0 = stall_seen;
    stall_from = cyc + 3; stall_len = 5;
    send_pkt(12'h0F0, 4);
    drain();
    chk("t5_stall_cycles", (stall_seen - s0 >= 5) ? 1 : 0, 1);

    do_cmd(INS, 12'h055, 11'h010, st); chk("t6_insert_ok", st, OK);
    drain();
    s0 = rsp_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = UPD; cmd_key = 12'h055; cmd_qid = 11'h020;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    s_axis_tdata = rnd_data(); s_axis_tdata[KEY_LSB +: KEY_W] = 12'h055;
    s_axis_tkeep = '1; s_axis_tlast = 1'b1; s_axis_tuser_size = 16'd64; s_axis_tvalid = 1'b1;
    @(posedge clk); #1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    chk("t6_update_rsp", rsp_cnt - s0, 1);
    expect_last_qid("t6_race_old_qid", 11'h010);
    send_pkt(12'h055, 2);
    expect_last_qid("t6_race_new_qid", 11'h020);

    rand_bp = 1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int r;
          logic [1:0] op;
          r = $urandom_range(0, 19);
          op = (r < 9) ? INS : (r < 13) ? UPD : (r < 18) ? DEL : (r == 18) ? FLU : INS;
          do_cmd(op, 12'h200 + 12'($urandom_range(0, 19)), 11'($urandom), st);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          logic [KEY_W-1:0] k;
          k = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h200 + 12'($urandom_range(0, 19));
          send_pkt(k, $urandom_range(1, 4));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join
    rand_bp = 0;
    drain();
    chk("rand_queue_empty", exp_q.size(), 0);

`ifdef ARFS_STEER_STATS_EN
    @(negedge clk);
    chk("stat_hit_cnt", stat_hit_cnt, mdl_hit);
    chk("stat_miss_cnt", stat_miss_cnt, mdl_miss);
    @(posedge clk); #1; stat_clr = 1'b1;
    @(posedge clk); #1; stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_hit_clr", stat_hit_cnt, 0);
    chk("stat_miss_clr", stat_miss_cnt, 0);
`endif

    do_cmd(INS, 12'h0AA, 11'h033, st);
    send_pkt(12'h0AA, 1);
    expect_last_qid("t7_pre_reset_hit", 11'h033);
    @(posedge clk); #1;
    s_axis_tdata = rnd_data(); s_axis_tdata[KEY_LSB +: KEY_W] = 12'h0AA;
    s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tuser_size = 16'd192; s_axis_tvalid = 1'b1;
    cmd_valid = 1'b1; cmd_op = INS; cmd_key = 12'h0BB; cmd_qid = 11'h005;
    @(posedge clk); #1; s_axis_tvalid = 1'b0; cmd_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("t7_rst_m_tvalid", m_axis_tvalid, 0);
    chk("t7_rst_qid", m_axis_tuser_qid, DEFAULT_QID);
    chk("t7_rst_cmd_ready", cmd_ready, 1);
    chkw("t7_rst_m_tdata", m_axis_tdata, '0);
    @(posedge clk); #1; aresetn = 1'b1;
    s0 = rsp_cnt;
    repeat (6) @(posedge clk);
    chk("t7_no_rsp_after_reset", rsp_cnt - s0, 0);
    send_pkt(12'h0AA, 1);
    expect_last_qid("t7_table_cleared", 11'h000);
    send_pkt(12'h0BB, 1);
    expect_last_qid("t7_cmd_dropped", 11'h000);
`ifdef ARFS_STEER_STATS_EN
    @(negedge clk);
    chk("t7_stat_miss", stat_miss_cnt, mdl_miss);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
